// File: rtl/fir_tb_pkg.sv
// Shared types and sizing for the FIR vector source endpoint.
package fir_tb_pkg;

    localparam int unsigned W     = 32;
    localparam int unsigned DEPTH = 64;
    localparam int unsigned AW    = 6;

    typedef enum logic [1:0] {
        IDLE,
        PLAY,
        DRAIN,
        DONE
    } src_state_t;

    // One playback entry: the sample driven to the harness and its golden output.
    typedef struct packed {
        logic [W-1:0] sample;
        logic [W-1:0] gold;
    } vec_pair_t;

endpackage

// File: rtl/fir_vec_ram.sv
// Simple dual-port RAM: one write port, one registered read port (old data on collision).
module fir_vec_ram #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 64,
    parameter int unsigned AW    = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             re_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Read register is cleared by reset so downstream outputs start at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_o <= '0;
        end else if (re_i) begin
            rdata_o <= mem_q[raddr_i];
        end
    end

endmodule

// File: rtl/fir_vector_source.sv
// Replays preloaded samples/golden values to the FIR+SSE harness and captures its filtered outputs.
module fir_vector_source
    import fir_tb_pkg::*;
#(
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_we,
    input  logic [AW-1:0] load_addr,
    input  logic [W-1:0]  load_in,
    input  logic [W-1:0]  load_gold,
    input  logic [AW:0]   count,
    input  logic          start,
    input  logic          next,
    input  logic          ready,
    input  logic [W-1:0]  out_filt,
    input  logic [W-1:0]  out_sse,
    output logic [W-1:0]  in,
    output logic [W-1:0]  out_gold,
    output logic          stop,
    output logic          busy,
    output logic          done,
    output logic          timeout,
    output logic [AW:0]   result_count,
    output logic [W-1:0]  final_sse,
    input  logic [AW-1:0] rd_addr,
    output logic [W-1:0]  rd_filt
);

    localparam int unsigned CW = AW + 1;
    localparam int unsigned IW = $clog2(TIMEOUT + 1);

    src_state_t    state_q, state_d;
    logic [CW-1:0] eff_q, eff_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic [IW-1:0] idle_q, idle_d;
    logic [CW-1:0] rcount_q, rcount_d;
    logic [W-1:0]  sse_q, sse_d;
    logic          stop_q, stop_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          timeout_q, timeout_d;

    logic          vec_we_c;
    logic          vec_re_c;
    logic [AW-1:0] vec_raddr_c;
    logic          cap_c;
    vec_pair_t     vec_wdata;
    vec_pair_t     vec_rdata;

    assign vec_wdata.sample = load_in;
    assign vec_wdata.gold   = load_gold;

    always_comb begin
        state_d     = state_q;
        eff_d       = eff_q;
        ptr_d       = ptr_q;
        idle_d      = idle_q;
        rcount_d    = rcount_q;
        sse_d       = sse_q;
        timeout_d   = timeout_q;
        vec_re_c    = 1'b0;
        vec_raddr_c = ptr_q + AW'(1);

        vec_we_c = load_we && (state_q == IDLE || state_q == DONE);
        cap_c    = (state_q == PLAY || state_q == DRAIN) && ready && (rcount_q < eff_q);

        if (cap_c) begin
            rcount_d = rcount_q + CW'(1);
            sse_d    = out_sse;
        end

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    timeout_d = 1'b0;
                    rcount_d  = '0;
                    ptr_d     = '0;
                    if (count == '0) begin
                        eff_d   = '0;
                        state_d = DONE;
                    end else begin
                        eff_d       = (count > CW'(DEPTH)) ? CW'(DEPTH) : count;
                        state_d     = PLAY;
                        // Prefetch entry 0 so it is on the outputs the cycle after start.
                        vec_re_c    = 1'b1;
                        vec_raddr_c = '0;
                    end
                end
            end
            PLAY: begin
                if (next) begin
                    if ({1'b0, ptr_q} < eff_q - CW'(1)) begin
                        ptr_d    = ptr_q + AW'(1);
                        vec_re_c = 1'b1;
                    end else begin
                        state_d = DRAIN;
                        idle_d  = '0;
                    end
                end
            end
            DRAIN: begin
                idle_d = ready ? '0 : idle_q + IW'(1);
                if (rcount_d == eff_q) begin
                    state_d = DONE;
                end else if (idle_d == IW'(TIMEOUT)) begin
                    state_d   = DONE;
                    timeout_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        stop_d = (state_d == DRAIN) || (state_d == DONE);
        busy_d = (state_d == PLAY) || (state_d == DRAIN);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            eff_q     <= '0;
            ptr_q     <= '0;
            idle_q    <= '0;
            rcount_q  <= '0;
            sse_q     <= '0;
            stop_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            eff_q     <= eff_d;
            ptr_q     <= ptr_d;
            idle_q    <= idle_d;
            rcount_q  <= rcount_d;
            sse_q     <= sse_d;
            stop_q    <= stop_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            timeout_q <= timeout_d;
        end
    end

    fir_vec_ram #(
        .WIDTH ($bits(vec_pair_t)),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_vec_ram (
        .clk     (clk),
        .rst_n   (rst),
        .we_i    (vec_we_c),
        .waddr_i (load_addr),
        .wdata_i (vec_wdata),
        .re_i    (vec_re_c),
        .raddr_i (vec_raddr_c),
        .rdata_o (vec_rdata)
    );

    fir_vec_ram #(
        .WIDTH (W),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_res_ram (
        .clk     (clk),
        .rst_n   (rst),
        .we_i    (cap_c),
        .waddr_i (rcount_q[AW-1:0]),
        .wdata_i (out_filt),
        .re_i    (1'b1),
        .raddr_i (rd_addr),
        .rdata_o (rd_filt)
    );

    assign in           = vec_rdata.sample;
    assign out_gold     = vec_rdata.gold;
    assign stop         = stop_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign timeout      = timeout_q;
    assign result_count = rcount_q;
    assign final_sse    = sse_q;

endmodule

// File: tb/tb_fir_vector_source.sv
// Directed bench for fir_vector_source: playback, capture, zero count, timeout, saturation, reset.
module tb_fir_vector_source;
    import fir_tb_pkg::*;

    logic          clk = 1'b0;
    logic          rst;
    logic          load_we;
    logic [AW-1:0] load_addr;
    logic [W-1:0]  load_in;
    logic [W-1:0]  load_gold;
    logic [AW:0]   count;
    logic          start;
    logic          next;
    logic          ready;
    logic [W-1:0]  out_filt;
    logic [W-1:0]  out_sse;
    logic [W-1:0]  smp;
    logic [W-1:0]  out_gold;
    logic          stop;
    logic          busy;
    logic          done;
    logic          timeout;
    logic [AW:0]   result_count;
    logic [W-1:0]  final_sse;
    logic [AW-1:0] rd_addr;
    logic [W-1:0]  rd_filt;

    int n_checks = 0;
    int n_pass   = 0;

    fir_vector_source dut (
        .clk          (clk),
        .rst          (rst),
        .load_we      (load_we),
        .load_addr    (load_addr),
        .load_in      (load_in),
        .load_gold    (load_gold),
        .count        (count),
        .start        (start),
        .next         (next),
        .ready        (ready),
        .out_filt     (out_filt),
        .out_sse      (out_sse),
        .in           (smp),
        .out_gold     (out_gold),
        .stop         (stop),
        .busy         (busy),
        .done         (done),
        .timeout      (timeout),
        .result_count (result_count),
        .final_sse    (final_sse),
        .rd_addr      (rd_addr),
        .rd_filt      (rd_filt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic load(input int addr, input int sv, input int gv);
        load_we   = 1'b1;
        load_addr = AW'(addr);
        load_in   = W'(sv);
        load_gold = W'(gv);
        cyc();
        load_we   = 1'b0;
    endtask

    task automatic pulse_start(input int n);
        start = 1'b1;
        count = (AW+1)'(n);
        cyc();
        start = 1'b0;
    endtask

    task automatic pulse_next();
        next = 1'b1;
        cyc();
        next = 1'b0;
    endtask

    task automatic read_res(input int addr, input int exp, input string tag);
        rd_addr = AW'(addr);
        cyc();
        check(tag, 64'(rd_filt), 64'(exp));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cnt;
        int errs;
        int stop_idx;

        rst = 1'b0; load_we = 1'b0; load_addr = '0; load_in = '0; load_gold = '0;
        count = '0; start = 1'b0; next = 1'b0; ready = 1'b0;
        out_filt = '0; out_sse = '0; rd_addr = '0;
        #12;
        check("rst_in", 64'(smp), 64'd0);
        check("rst_stop", 64'(stop), 64'd0);
        check("rst_busy_done", 64'({busy, done, timeout}), 64'd0);
        check("rst_rcount", 64'(result_count), 64'd0);
        check("rst_sse", 64'(final_sse), 64'd0);
        check("rst_rdfilt", 64'(rd_filt), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        cyc();

        // count == 0 goes straight to DONE
        pulse_start(0);
        check("zero_done", 64'(done), 64'd1);
        check("zero_stop", 64'(stop), 64'd1);
        check("zero_busy", 64'(busy), 64'd0);
        check("zero_in", 64'(smp), 64'd0);

        // basic 4-sample run
        for (int i = 0; i < 4; i++) load(i, i + 1, 10 * (i + 1));
        pulse_start(4);
        check("run_in0", 64'(smp), 64'd1);
        check("run_gold0", 64'(out_gold), 64'd10);
        check("run_busy", 64'(busy), 64'd1);
        check("run_done_clr", 64'({done, stop}), 64'd0);
        for (int k = 1; k < 4; k++) begin
            repeat (4) cyc();
            pulse_next();
            check("run_in_step", 64'(smp), 64'(k + 1));
            check("run_gold_step", 64'(out_gold), 64'(10 * (k + 1)));
        end
        repeat (4) cyc();
        check("run_stop_pre", 64'(stop), 64'd0);
        pulse_next();
        check("run_stop", 64'(stop), 64'd1);
        check("run_in_hold", 64'(smp), 64'd4);
        for (int i = 0; i < 4; i++) begin
            ready    = 1'b1;
            out_filt = W'(5 + i);
            case (i)
                0: out_sse = 32'd25;
                1: out_sse = 32'd41;
                2: out_sse = 32'd50;
                default: out_sse = 32'd66;
            endcase
            cyc();
        end
        ready = 1'b0;
        check("run_rcount", 64'(result_count), 64'd4);
        check("run_done", 64'(done), 64'd1);
        check("run_sse", 64'(final_sse), 64'd66);
        check("run_busy_end", 64'(busy), 64'd0);
        for (int i = 0; i < 4; i++) read_res(i, 5 + i, "run_rd");

        // timeout: 3 samples, only one result
        pulse_start(3);
        check("to_done_clr", 64'({done, stop}), 64'd0);
        ready = 1'b1; out_filt = 32'd77; out_sse = 32'd9;
        pulse_next();
        ready = 1'b0;
        cyc();
        pulse_next();
        cyc();
        pulse_next();
        check("to_drain", 64'({stop, busy}), 64'd3);
        cnt = 0;
        while (!done && cnt < 1200) begin
            cyc();
            cnt++;
        end
        check("to_cycles", 64'(cnt), 64'd1024);
        check("to_flags", 64'({done, timeout}), 64'd3);
        check("to_rcount", 64'(result_count), 64'd1);
        check("to_sse", 64'(final_sse), 64'd9);
        read_res(0, 77, "to_rd");

        // saturation: count 100 plays exactly DEPTH entries
        for (int i = 0; i < 64; i++) load(i, i + 100, i);
        pulse_start(100);
        check("sat_timeout_clr", 64'(timeout), 64'd0);
        errs = 0;
        stop_idx = 0;
        for (int i = 0; i < 64; i++) begin
            if (smp != W'(i + 100) || out_gold != W'(i)) errs++;
            if (stop && stop_idx == 0) stop_idx = i;
            next = 1'b1; ready = 1'b1;
            out_filt = W'(i + 1000); out_sse = W'(i);
            cyc();
            if (stop && stop_idx == 0) stop_idx = i + 1;
        end
        next = 1'b0;
        check("sat_seq", 64'(errs), 64'd0);
        check("sat_stop_at", 64'(stop_idx), 64'd64);
        out_filt = 32'hDEAD; out_sse = 32'hBEEF;
        cyc();
        ready = 1'b0;
        check("sat_rcount", 64'(result_count), 64'd64);
        check("sat_sse", 64'(final_sse), 64'd63);
        check("sat_done", 64'(done), 64'd1);
        read_res(0, 1000, "sat_rd0");
        read_res(63, 1063, "sat_rd63");

        // async reset mid-PLAY at ptr == 2
        pulse_start(5);
        ready = 1'b1; out_filt = 32'd1; out_sse = 32'd1;
        pulse_next();
        ready = 1'b0;
        pulse_next();
        check("mid_in2", 64'(smp), 64'd102);
        check("mid_rcount_pre", 64'(result_count), 64'd1);
        #2 rst = 1'b0;
        #1;
        check("mid_rst_flags", 64'({stop, busy, done}), 64'd0);
        check("mid_rst_rcount", 64'(result_count), 64'd0);
        check("mid_rst_in", 64'(smp), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        cyc();
        pulse_start(5);
        check("replay_in0", 64'(smp), 64'd100);
        pulse_next();
        check("replay_in1", 64'(smp), 64'd101);
        check("replay_gold1", 64'(out_gold), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
